sdram_rd_tx_pacer: RTL

//  Drains one burst of words from the SDRAM read FIFO (rd_fifo_rd_clk = clk_50m) and feeds

---
 rtl/sdram_rd_tx_pacer_pkg.sv | 34 +++
 rtl/sdram_rd_tx_pacer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/sdram_rd_tx_pacer_pkg.sv
// Shared definitions for the SDRAM read-FIFO to UART pacer: default timing
// constants, counter widths, FSM state encoding and small helpers.
package sdram_rd_tx_pacer_pkg;

   localparam int DEF_CLK_FREQ   = 50_000_000;
   localparam int DEF_UART_BPS   = 9600;
   localparam int DEF_FRAME_BITS = 10;
   localparam int DEF_GUARD_CYC  = 16;

   localparam int GAP_W  = 20;
   localparam int WCNT_W = 10;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RD_REQ  = 3'd1,
      ST_RD_LAT  = 3'd2,
      ST_SEND_LO = 3'd3,
      ST_GAP     = 3'd4,
      ST_SEND_HI = 3'd5
   } pacer_state_t;

   // Cycles one UART frame occupies on the line, plus the idle guard.
   function automatic int frame_cycles(input int clk_freq, input int bps,
                                       input int frame_bits, input int guard);
      return (clk_freq / bps) * frame_bits + guard;
   endfunction

   // A burst may start only when a non-zero burst is fully buffered.
   function automatic logic burst_ready(input logic [WCNT_W-1:0] bn,
                                        input logic [WCNT_W-1:0] num);
      return (bn != '0) && (num >= bn);
   endfunction

endpackage

// File: rtl/sdram_rd_tx_pacer.sv
// sdram_rd_tx_pacer: waits for a full burst in the SDRAM read FIFO, then
// reads it one word at a time and hands one byte per UART frame to uart_tx.
module sdram_rd_tx_pacer
   import sdram_rd_tx_pacer_pkg::*;
#(
   parameter int CLK_FREQ   = DEF_CLK_FREQ,
   parameter int UART_BPS   = DEF_UART_BPS,
   parameter int FRAME_BITS = DEF_FRAME_BITS,
   parameter int GUARD_CYC  = DEF_GUARD_CYC,
   parameter int SEND_HI    = 0
) (
   input  logic        clk_50m,
   input  logic        rst_n,
   input  logic [9:0]  rd_fifo_num,
   input  logic [15:0] rd_fifo_rd_data,
   input  logic [9:0]  burst_num,
   output logic        rd_en,
   output logic [7:0]  tx_data,
   output logic        tx_flag,
   output logic        busy
);

   localparam int               FRAME_CNT = frame_cycles(CLK_FREQ, UART_BPS,
                                                         FRAME_BITS, GUARD_CYC);
   localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(FRAME_CNT - 1);

   pacer_state_t      state_q;
   logic [WCNT_W-1:0] bn_q;
   logic [WCNT_W-1:0] word_cnt_q;
   logic [WCNT_W-1:0] word_cnt_d;
   logic [GAP_W-1:0]  gap_cnt_q;
   logic [7:0]        hi_byte_q;
   logic              hi_pend_q;
   logic              rd_en_q;
   logic              tx_flag_q;
   logic [7:0]        tx_data_q;
   logic              busy_q;

   assign word_cnt_d = word_cnt_q + 10'd1;

   assign rd_en   = rd_en_q;
   assign tx_flag = tx_flag_q;
   assign tx_data = tx_data_q;
   assign busy    = busy_q;

   // Pacer FSM: burst admission, one FIFO read per word, frame-rate byte pacing.
   // RD_LAT covers the FIFO's one-cycle read latency; the word is taken from
   // the FIFO output on the edge leaving SEND_LO, when q is guaranteed valid.
   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         bn_q       <= '0;
         word_cnt_q <= '0;
         gap_cnt_q  <= '0;
         hi_byte_q  <= 8'h00;
         hi_pend_q  <= 1'b0;
         rd_en_q    <= 1'b0;
         tx_flag_q  <= 1'b0;
         tx_data_q  <= 8'h00;
         busy_q     <= 1'b0;
      end else begin
         // Strobes default low so each is a single-cycle pulse.
         rd_en_q   <= 1'b0;
         tx_flag_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (burst_ready(burst_num, rd_fifo_num)) begin
                  bn_q       <= burst_num;
                  word_cnt_q <= '0;
                  busy_q     <= 1'b1;
                  state_q    <= ST_RD_REQ;
               end
            end
            ST_RD_REQ: begin
               // Never read an empty FIFO; hold here until a word shows up.
               if (rd_fifo_num != '0) begin
                  rd_en_q <= 1'b1;
                  state_q <= ST_RD_LAT;
               end
            end
            ST_RD_LAT: begin
               state_q <= ST_SEND_LO;
            end
            ST_SEND_LO: begin
               tx_data_q <= rd_fifo_rd_data[7:0];
               hi_byte_q <= rd_fifo_rd_data[15:8];
               tx_flag_q <= 1'b1;
               hi_pend_q <= (SEND_HI != 0);
               gap_cnt_q <= '0;
               state_q   <= ST_GAP;
            end
            ST_GAP: begin
               if (gap_cnt_q == GAP_LAST) begin
                  gap_cnt_q <= '0;
                  if (hi_pend_q) begin
                     state_q <= ST_SEND_HI;
                  end else begin
                     word_cnt_q <= word_cnt_d;
                     if (word_cnt_d == bn_q) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                     end else begin
                        state_q <= ST_RD_REQ;
                     end
                  end
               end else begin
                  gap_cnt_q <= gap_cnt_q + 20'd1;
               end
            end
            ST_SEND_HI: begin
               tx_data_q <= hi_byte_q;
               tx_flag_q <= 1'b1;
               hi_pend_q <= 1'b0;
               gap_cnt_q <= '0;
               state_q   <= ST_GAP;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
